matrix_result_reader: RTL

Reads a stored result matrix out of the shared matrix storage and streams its elements, row-major, over a valid/ready interface to a downstream consumer (display/UART formatter). The calculator core writes results into storage; this block is the read side of that same layout: dimension words at BASE and BASE+1, elements from BASE+2. It drives the storage read address through the storage MUX and holds a bus request for the whole transfer.

---
 rtl/matrix_result_reader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_result_reader.sv
// Streams a stored result matrix (dims at BASE_ADDR/BASE_ADDR+1, elements from
// BASE_ADDR+2) row-major over a valid/ready interface.
module matrix_result_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 64,
    parameter int MAX_DIM   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              bus_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_row,
    output logic [2:0]        out_col,
    output logic              out_last,
    output logic [2:0]        dim_rows,
    output logic [2:0]        dim_cols,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, RD_ROW, RD_COL, CHECK, RD_ELEM, PRESENT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ROW_ADDR  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] COL_ADDR  = ADDR_W'(BASE_ADDR + 1);
    localparam logic [ADDR_W-1:0] ELEM_ADDR = ADDR_W'(BASE_ADDR + 2);
    localparam logic [DATA_W-1:0] MAX_W     = DATA_W'(MAX_DIM);

    state_t state, state_n;

    logic [DATA_W-1:0] rows_w, cols_w, rows_w_n, cols_w_n;
    logic [2:0]        i_idx, j_idx, i_idx_n, j_idx_n;
    logic [ADDR_W-1:0] rd_addr_n;
    logic [DATA_W-1:0] out_data_n;
    logic [2:0]        out_row_n, out_col_n, dim_rows_n, dim_cols_n;
    logic              bus_req_n, out_valid_n, out_last_n, busy_n, done_n, err_n;
    logic              dims_ok;

    // Full-word compare: any nonzero upper bit makes the dimension illegal.
    assign dims_ok = (rows_w >= DATA_W'(1)) && (rows_w <= MAX_W) &&
                     (cols_w >= DATA_W'(1)) && (cols_w <= MAX_W);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RD_ROW;
            RD_ROW:  state_n = RD_COL;
            RD_COL:  state_n = CHECK;
            CHECK:   state_n = dims_ok ? RD_ELEM : DONE;
            RD_ELEM: state_n = PRESENT;
            PRESENT: if (out_ready) state_n = out_last ? DONE : RD_ELEM;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_addr_n   = rd_addr;
        bus_req_n   = bus_req;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_row_n   = out_row;
        out_col_n   = out_col;
        out_last_n  = out_last;
        dim_rows_n  = dim_rows;
        dim_cols_n  = dim_cols;
        rows_w_n    = rows_w;
        cols_w_n    = cols_w;
        i_idx_n     = i_idx;
        j_idx_n     = j_idx;
        err_n       = err;
        // busy lags the state by one cycle so it falls together with done
        busy_n      = done ? 1'b0 : busy;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    rd_addr_n = ROW_ADDR;
                    bus_req_n = 1'b1;
                    err_n     = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            RD_ROW: begin
                rows_w_n  = rd_data;
                rd_addr_n = COL_ADDR;
            end
            RD_COL: cols_w_n = rd_data;
            CHECK: begin
                if (dims_ok) begin
                    dim_rows_n = rows_w[2:0];
                    dim_cols_n = cols_w[2:0];
                    i_idx_n    = '0;
                    j_idx_n    = '0;
                    rd_addr_n  = ELEM_ADDR;
                end else begin
                    err_n = 1'b1;
                end
            end
            RD_ELEM: begin
                out_data_n  = rd_data;
                out_row_n   = i_idx;
                out_col_n   = j_idx;
                out_last_n  = (i_idx == dim_rows - 3'd1) && (j_idx == dim_cols - 3'd1);
                out_valid_n = 1'b1;
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    if (!out_last) begin
                        if (j_idx == dim_cols - 3'd1) begin
                            j_idx_n = '0;
                            i_idx_n = i_idx + 3'd1;
                        end else begin
                            j_idx_n = j_idx + 3'd1;
                        end
                        rd_addr_n = rd_addr + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                done_n     = 1'b1;
                bus_req_n  = 1'b0;
                out_last_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            bus_req   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            dim_rows  <= '0;
            dim_cols  <= '0;
            rows_w    <= '0;
            cols_w    <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_addr   <= rd_addr_n;
            bus_req   <= bus_req_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_row   <= out_row_n;
            out_col   <= out_col_n;
            out_last  <= out_last_n;
            dim_rows  <= dim_rows_n;
            dim_cols  <= dim_cols_n;
            rows_w    <= rows_w_n;
            cols_w    <= cols_w_n;
            i_idx     <= i_idx_n;
            j_idx     <= j_idx_n;
            err       <= err_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule
